// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter sequencing one fixed-latency memory port
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LAT_W = $clog2(RD_LATENCY + 1);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    // WAIT_RD is entered one cycle after ISSUE, so the countdown starts one short
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t            state, state_nx;
    logic [LAT_W-1:0]  lat_cnt, lat_nx;
    logic [CNT_W-1:0]  starve_cnt, starve_nx;
    logic              win_dm, win_dm_nx;
    logic              we_q, we_nx;
    logic              pick_if;

    logic              if_gnt_nx, if_rvalid_nx, dm_gnt_nx, dm_rvalid_nx;
    logic [DATA_W-1:0] if_rdata_nx, dm_rdata_nx;
    logic              mem_en_nx, mem_rd_wr_nx;
    logic [ADDR_W-1:0] mem_add_nx;
    logic [DATA_W-1:0] mem_data_nx;

    assign pick_if = if_req && (!dm_req || (starve_cnt == CNT_MAX));

    always_comb begin
        state_nx     = state;
        lat_nx       = lat_cnt;
        starve_nx    = starve_cnt;
        win_dm_nx    = win_dm;
        we_nx        = we_q;
        if_gnt_nx    = 1'b0;
        dm_gnt_nx    = 1'b0;
        if_rvalid_nx = 1'b0;
        dm_rvalid_nx = 1'b0;
        if_rdata_nx  = if_rdata;
        dm_rdata_nx  = dm_rdata;
        mem_en_nx    = 1'b0;
        mem_rd_wr_nx = 1'b0;
        mem_add_nx   = '0;
        mem_data_nx  = '0;
        case (state)
            IDLE: begin
                if (!if_req || pick_if) begin
                    starve_nx = '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_nx = starve_cnt + CNT_W'(1);
                end
                if (if_req || dm_req) begin
                    state_nx  = ISSUE;
                    mem_en_nx = 1'b1;
                    win_dm_nx = !pick_if;
                    if (pick_if) begin
                        we_nx      = 1'b0;
                        mem_add_nx = if_addr;
                        if_gnt_nx  = 1'b1;
                    end else begin
                        we_nx        = dm_we;
                        mem_rd_wr_nx = dm_we;
                        mem_add_nx   = dm_addr;
                        mem_data_nx  = dm_wdata;
                        dm_gnt_nx    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                lat_nx   = LAT_LOAD;
                state_nx = we_q ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (lat_cnt == '0) begin
                    state_nx = IDLE;
                    if (win_dm) begin
                        dm_rdata_nx  = mem_rdata;
                        dm_rvalid_nx = 1'b1;
                    end else begin
                        if_rdata_nx  = mem_rdata;
                        if_rvalid_nx = 1'b1;
                    end
                end else begin
                    lat_nx = lat_cnt - LAT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            win_dm     <= 1'b0;
            we_q       <= 1'b0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_rd_wr  <= 1'b0;
            mem_add    <= '0;
            mem_data   <= '0;
        end else begin
            state      <= state_nx;
            lat_cnt    <= lat_nx;
            starve_cnt <= starve_nx;
            win_dm     <= win_dm_nx;
            we_q       <= we_nx;
            if_gnt     <= if_gnt_nx;
            dm_gnt     <= dm_gnt_nx;
            if_rvalid  <= if_rvalid_nx;
            dm_rvalid  <= dm_rvalid_nx;
            if_rdata   <= if_rdata_nx;
            dm_rdata   <= dm_rdata_nx;
            mem_en     <= mem_en_nx;
            mem_rd_wr  <= mem_rd_wr_nx;
            mem_add    <= mem_add_nx;
            mem_data   <= mem_data_nx;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int L     = 2;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_rd_wr;
    logic [31:0] mem_add, mem_data, mem_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add), .mem_data(mem_data),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } dm_t;

    logic [31:0] if_q[$];
    dm_t         dm_q[$];
    logic [31:0] dm_model[logic [31:0]];
    logic [31:0] tbmem[logic [31:0]];

    int n_vec = 0;
    int n_fail = 0;
    int if_pct, dm_pct, wr_pct;
    bit stim_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    task automatic new_if();
        if_addr = 32'h0001_0000 + 32'($urandom_range(255)) * 32'd4;
        if_q.push_back(if_addr);
        if_req = 1'b1;
    endtask

    task automatic new_dm();
        dm_t e;
        dm_addr  = 32'h0000_0200 + 32'($urandom_range(15)) * 32'd4;
        dm_we    = ($urandom_range(99) < wr_pct);
        dm_wdata = $urandom;
        e.we    = dm_we;
        e.addr  = dm_addr;
        e.wdata = dm_wdata;
        e.rdata = dm_model.exists(dm_addr) ? dm_model[dm_addr] : hash(dm_addr);
        if (dm_we) dm_model[dm_addr] = dm_wdata;
        dm_q.push_back(e);
        dm_req = 1'b1;
    endtask

    // requester agents: hold req until gnt, release or re-request the cycle after
    bit if_gf = 0, dm_gf = 0;
    initial begin
        forever begin
            @(posedge clock); #1;
            if (if_gf) begin
                if_gf = 0;
                if (stim_on && $urandom_range(99) < if_pct) new_if(); else if_req = 1'b0;
            end else if (!if_req && stim_on && $urandom_range(99) < if_pct) new_if();
            if (if_gnt === 1'b1) if_gf = 1;
            if (dm_gf) begin
                dm_gf = 0;
                if (stim_on && $urandom_range(99) < dm_pct) new_dm(); else dm_req = 1'b0;
            end else if (!dm_req && stim_on && $urandom_range(99) < dm_pct) new_dm();
            if (dm_gnt === 1'b1) dm_gf = 1;
        end
    end

    // memory: returns data exactly L cycles after the issue cycle, noise otherwise
    bit          mp = 0;
    int          mp_due;
    logic [31:0] mp_addr;
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clock); #1;
            if (mp && mp_due == cyc) begin
                mem_rdata = tbmem.exists(mp_addr) ? tbmem[mp_addr] : hash(mp_addr);
                mp = 0;
            end else begin
                mem_rdata = $urandom;
            end
            if (mem_en === 1'b1) begin
                if (mem_rd_wr) tbmem[mem_add] = mem_data;
                else begin
                    mp = 1; mp_addr = mem_add; mp_due = cyc + L;
                end
            end
        end
    end

    // reference model: port free from next_idle on; starvation counted in lost decisions
    int          next_idle = 0;
    int          lost = 0;
    bit          pv = 0, p_is_if;
    int          p_due;
    logic [31:0] p_data;
    bit          p_if = 0, p_dm = 0, prev_reset = 0;
    bit          exp_g, exp_if, exp_ifv, exp_dmv, dec;
    logic [31:0] a;
    dm_t         e;

    always @(negedge clock) begin
        if (cyc > 0) begin
            if (prev_reset) begin
                chk("reset_zero", 64'(|{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
                                        mem_en, mem_rd_wr, mem_add, mem_data}), 64'd0);
                pv = 0; next_idle = cyc; lost = 0;
            end else begin
                exp_ifv = pv && p_due == cyc && p_is_if;
                exp_dmv = pv && p_due == cyc && !p_is_if;
                chk("if_rvalid", 64'(if_rvalid), 64'(exp_ifv));
                chk("dm_rvalid", 64'(dm_rvalid), 64'(exp_dmv));
                if (exp_ifv) chk("if_rdata", 64'(if_rdata), 64'(p_data));
                if (exp_dmv) chk("dm_rdata", 64'(dm_rdata), 64'(p_data));
                if (pv && p_due == cyc) pv = 0;

                dec    = (cyc - 1 >= next_idle);
                exp_g  = dec && (p_if || p_dm);
                exp_if = p_if && (!p_dm || lost == LIMIT);
                if (dec) begin
                    if (!p_if || exp_if) lost = 0;
                    else if (lost < LIMIT) lost++;
                end
                chk("gnt_any", 64'(if_gnt | dm_gnt), 64'(exp_g));
                if (exp_g) begin
                    chk("gnt_if", 64'(if_gnt), 64'(exp_if));
                    chk("gnt_dm", 64'(dm_gnt), 64'(!exp_if));
                    chk("mem_en", 64'(mem_en), 64'd1);
                    if (exp_if) begin
                        if (if_q.size() == 0) chk("if_q_underflow", 64'd1, 64'd0);
                        else begin
                            a = if_q.pop_front();
                            chk("if_mem_add", 64'(mem_add), 64'(a));
                            chk("if_mem_rd_wr", 64'(mem_rd_wr), 64'd0);
                            chk("if_mem_data", 64'(mem_data), 64'd0);
                            next_idle = cyc + L + 1;
                            pv = 1; p_is_if = 1; p_due = cyc + L + 1; p_data = hash(a);
                        end
                    end else begin
                        if (dm_q.size() == 0) chk("dm_q_underflow", 64'd1, 64'd0);
                        else begin
                            e = dm_q.pop_front();
                            chk("dm_mem_add", 64'(mem_add), 64'(e.addr));
                            chk("dm_mem_rd_wr", 64'(mem_rd_wr), 64'(e.we));
                            if (e.we) begin
                                chk("dm_mem_data", 64'(mem_data), 64'(e.wdata));
                                next_idle = cyc + 1;
                            end else begin
                                next_idle = cyc + L + 1;
                                pv = 1; p_is_if = 0; p_due = cyc + L + 1; p_data = e.rdata;
                            end
                        end
                    end
                end else begin
                    chk("mem_idle", 64'(|{mem_en, mem_rd_wr, mem_add, mem_data}), 64'd0);
                end
            end
        end
        p_if = if_req; p_dm = dm_req; prev_reset = reset;
    end

    task automatic drain();
        int n = 0;
        stim_on = 0;
        while ((if_req || dm_req || pv) && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        chk("drain_timeout", 64'(n >= 100), 64'd0);
        repeat (3) @(posedge clock);
        #2;
    endtask

    initial begin
        int n;
        reset = 1'b1; stim_on = 0;
        if_req = 1'b0; dm_req = 1'b0; if_addr = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_pct = 50; dm_pct = 50; wr_pct = 0;
        // both requesters waiting through a 3-cycle reset; DM must win first
        new_if();
        new_dm();
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        // saturated DM reads against IF: exercises the starvation rotation
        if_pct = 100; dm_pct = 100; wr_pct = 0; stim_on = 1;
        repeat (80) @(posedge clock);
        #2;
        for (int s = 0; s < 6; s++) begin
            if_pct = $urandom_range(10, 95);
            dm_pct = $urandom_range(10, 95);
            wr_pct = $urandom_range(0, 100);
            repeat (400) @(posedge clock);
            #2;
        end
        drain();
        // reset while a DM read is waiting for memory
        wr_pct = 0;
        new_dm();
        n = 0;
        while (dm_gnt !== 1'b1 && n < 20) begin
            @(posedge clock); #2;
            n++;
        end
        chk("t5_gnt_timeout", 64'(n >= 20), 64'd0);
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        new_if();
        repeat (12) @(posedge clock);
        #2;
        drain();
        chk("if_q_left", 64'(if_q.size()), 64'd0);
        chk("dm_q_left", 64'(dm_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
